// File: rtl/dmem_pkg.sv
// dmem_pkg: error codes and FSM state shared by dmem_banked and its storage array
package dmem_pkg;
  localparam logic [1:0] DMEM_OK       = 2'b00;
  localparam logic [1:0] DMEM_MISALIGN = 2'b01;
  localparam logic [1:0] DMEM_RANGE    = 2'b10;
  localparam logic [1:0] DMEM_PARITY   = 2'b11;
  typedef enum logic {CLEAR, RUN} dmem_state_t;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x DATA_W word store, byte-lane writes, registered read port
// DMEM_PARITY_EN adds one even-parity bit per lane, checked on the registered read word
module dmem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  localparam int AW    = $clog2(DEPTH),
  localparam int NB    = DATA_W / 8
) (
  input  logic              clock,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [NB-1:0]     i_be,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_par_err
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_q;
  always_ff @(posedge clock) begin
    for (int i = 0; i < NB; i++)
      if (i_we && i_be[i]) r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
    r_q <= r_mem[i_raddr];
  end
  assign o_rdata = r_q;
`ifdef DMEM_PARITY_EN
  logic [NB-1:0] r_par [DEPTH];
  logic [NB-1:0] r_par_q;
  logic [NB-1:0] w_calc;
  always_ff @(posedge clock) begin
    for (int i = 0; i < NB; i++)
      if (i_we && i_be[i]) r_par[i_waddr][i] <= ^i_wdata[8*i +: 8];
    r_par_q <= r_par[i_raddr];
  end
  always_comb begin
    w_calc = '0;
    for (int i = 0; i < NB; i++) w_calc[i] = ^r_q[8*i +: 8];
  end
  assign o_par_err = |(w_calc ^ r_par_q);
`else
  assign o_par_err = 1'b0;
`endif
endmodule

// File: rtl/dmem_banked.sv
// dmem_banked: data memory with valid/ready requests, byte enables, power-on clear and error responses
// Optional per-lane parity checking is enabled with DMEM_PARITY_EN
module dmem_banked
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int NB    = DATA_W / 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [NB-1:0]     req_be,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic              init_done
);
  dmem_state_t r_state, w_next;
  logic [AW-1:0] r_cnt;
  logic w_clr, w_acc;
  logic [1:0] w_err, w_rsp_err;
  logic [AW-1:0] w_idx;
  logic [DATA_W-1:0] w_q;
  logic w_par_err;
  logic r_p_valid, r_p_rd;
  logic [1:0] r_p_err;
  logic r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic [1:0] r_rsp_err;
  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= CLEAR;
    else r_state <= w_next;
  end
  always_comb w_next = (r_state == CLEAR && r_cnt == AW'(DEPTH - 1)) ? RUN : r_state;
  always_comb begin
    req_ready = r_state == RUN;
    init_done = r_state == RUN;
  end
  always_ff @(posedge clock) begin
    if (!reset_n) r_cnt <= '0;
    else if (r_state == CLEAR) r_cnt <= r_cnt + 1'b1;
  end
  assign w_clr = r_state == CLEAR;
  assign w_acc = req_valid & req_ready;
  assign w_idx = req_addr[AW+1:2];
  assign w_err = (|req_addr[1:0]) ? DMEM_MISALIGN :
                 ((req_addr >> 2) >= ADDR_W'(DEPTH)) ? DMEM_RANGE : DMEM_OK;
  dmem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_array (
    .clock     (clock),
    .i_we      (w_clr | (w_acc & req_we & (w_err == DMEM_OK))),
    .i_waddr   (w_clr ? r_cnt : w_idx),
    .i_wdata   (w_clr ? '0 : req_wdata),
    .i_be      (w_clr ? '1 : req_be),
    .i_raddr   (w_idx),
    .o_rdata   (w_q),
    .o_par_err (w_par_err)
  );
  // The array read word lands one edge after accept, so the response is built a cycle later
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_p_valid <= 1'b0;
      r_p_rd    <= 1'b0;
      r_p_err   <= DMEM_OK;
    end else begin
      r_p_valid <= w_acc;
      r_p_rd    <= ~req_we;
      r_p_err   <= w_err;
    end
  end
  assign w_rsp_err = (r_p_err == DMEM_OK && r_p_rd && w_par_err) ? DMEM_PARITY : r_p_err;
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= DMEM_OK;
    end else begin
      r_rsp_valid <= r_p_valid;
      r_rsp_rdata <= (r_p_valid && r_p_rd && r_p_err == DMEM_OK) ? w_q : '0;
      r_rsp_err   <= r_p_valid ? w_rsp_err : DMEM_OK;
    end
  end
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
endmodule

// File: tb/tb_dmem_banked.sv
// tb_dmem_banked: directed and random requests against a word-array reference model of dmem_banked
module tb_dmem_banked;
  localparam int DEPTH = 1024;
  typedef struct packed {logic v; logic [31:0] d; logic [1:0] e;} rsp_t;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset_n, req_valid, req_ready, req_we, rsp_valid, init_done;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0] req_be;
  logic [1:0] rsp_err;
  int checks = 0, errors = 0;
  logic [31:0] m_mem [DEPTH];
  int m_cnt = 0;
  logic m_ready = 1'b0;
  rsp_t pend = '0, expr = '0;
  dmem_banked dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .init_done(init_done)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic v, input logic we, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] be, input logic rn);
    rsp_t nw;
    logic acc;
    int idx;
    reset_n = rn; req_valid = v; req_we = we; req_addr = a; req_wdata = d; req_be = be;
    acc = v && m_ready && rn;
    idx = int'((a / 4) % DEPTH);
    nw = '0;
    if (acc) begin
      nw.v = 1'b1;
      nw.e = (a % 4 != 0) ? 2'd1 : (a / 4 >= DEPTH) ? 2'd2 : 2'd0;
      nw.d = (!we && nw.e == 2'd0) ? m_mem[idx] : 32'd0;
      if (we && nw.e == 2'd0)
        for (int i = 0; i < 4; i++) if (be[i]) m_mem[idx][8*i +: 8] = d[8*i +: 8];
    end
    @(posedge clock);
    expr = rn ? pend : '0;
    pend = nw;
    if (!rn) begin
      m_cnt = 0;
      m_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'd0;
    end else if (!m_ready) begin
      m_cnt++;
      m_ready = (m_cnt == DEPTH);
    end
    @(negedge clock);
    chk("rsp_valid", 32'(rsp_valid), 32'(expr.v));
    chk("rsp_rdata", rsp_rdata, expr.d);
    chk("rsp_err", 32'(rsp_err), 32'(expr.e));
    chk("req_ready", 32'(req_ready), 32'(m_ready));
    chk("init_done", 32'(init_done), 32'(m_ready));
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 32'd0, 4'h0, 1'b1);
  endtask
  initial begin
    logic [31:0] a;
    int r;
    reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    @(negedge clock);
    step(1'b0, 1'b0, 32'd0, 32'd0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 32'd0, 32'd0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 32'd0, 32'd0, 4'h0, 1'b1);
    idle(DEPTH);
    step(1'b1, 1'b0, 32'd0, 32'd0, 4'h0, 1'b1);
    idle(2);
    step(1'b1, 1'b1, 32'd48, 32'd392544, 4'hF, 1'b1);
    step(1'b1, 1'b0, 32'd48, 32'd0, 4'h0, 1'b1);
    idle(2);
    step(1'b1, 1'b1, 32'd50, 32'd456, 4'hF, 1'b1);
    step(1'b1, 1'b0, 32'd48, 32'd0, 4'h0, 1'b1);
    idle(2);
    step(1'b1, 1'b1, 32'd100000, 32'd154869, 4'hF, 1'b1);
    step(1'b1, 1'b0, 32'd100000, 32'd0, 4'h0, 1'b1);
    idle(2);
    step(1'b1, 1'b1, 32'd24, 32'h11223344, 4'hF, 1'b1);
    step(1'b1, 1'b1, 32'd24, 32'hAABBCCDD, 4'b0101, 1'b1);
    step(1'b1, 1'b0, 32'd24, 32'd0, 4'h0, 1'b1);
    step(1'b1, 1'b1, 32'd24, 32'h55555555, 4'h0, 1'b1);
    step(1'b1, 1'b0, 32'd24, 32'd0, 4'h0, 1'b1);
    step(1'b1, 1'b1, 32'd4092, 32'hCAFEF00D, 4'hF, 1'b1);
    step(1'b1, 1'b0, 32'd4092, 32'd0, 4'h0, 1'b1);
    step(1'b1, 1'b0, 32'd4096, 32'd0, 4'h0, 1'b1);
    step(1'b1, 1'b0, 32'd4098, 32'd0, 4'h0, 1'b1);
    idle(2);
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 9));
      a = 32'($urandom_range(0, 15)) * 4;
      if (r == 0) a = a + 32'($urandom_range(1, 3));
      else if (r == 1) a = 32'd4096 + (($urandom % 32'h00FF_FFFF) << 2);
      else if (r == 2) a = $urandom | 32'h0000_1001;
      step($urandom_range(0, 3) != 0, 1'($urandom), a, $urandom, 4'($urandom), 1'b1);
    end
    idle(2);
    step(1'b1, 1'b0, 32'd48, 32'd0, 4'h0, 1'b0);
    idle(DEPTH);
    step(1'b1, 1'b0, 32'd48, 32'd0, 4'h0, 1'b1);
    idle(2);
    step(1'b1, 1'b1, 32'd8, 32'h12345678, 4'hF, 1'b1);
    step(1'b1, 1'b0, 32'd8, 32'd0, 4'h0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 32'd0, 4'h0, 1'b0);
    idle(DEPTH);
    step(1'b1, 1'b0, 32'd8, 32'd0, 4'h0, 1'b1);
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_banked.md
# dmem_banked

Parametrised synchronous data memory for the Beta datapath, successor to the fixed single-port `Datamemory`. Adds:
- a valid/ready request handshake;
- byte-lane write enables;
- a registered response with error reporting for misaligned and out-of-range addresses;
- a power-on clear sweep that zeroes the array before the first access.

Sits between the Beta memory stage and the word storage array, one request per cycle.

## Interface
- `DATA_W`, 32, word width in bits; multiple of 8.
- `DEPTH`, 1024, number of words; power of two, ≥ 4.
- `ADDR_W`, 32, byte-address width.
- `clock` in 1: single clock, all state on rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request this cycle.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in `ADDR_W`: byte address.
- `req_wdata` in `DATA_W`: write data.
- `req_be` in `DATA_W/8`: byte-lane write enables; bit i covers bits [8i+7:8i].
- `rsp_valid` out 1: response valid, one-cycle pulse.
- `rsp_rdata` out `DATA_W`: read data; 0 for writes and errors.
- `rsp_err` out 2: 00 ok, 01 misaligned, 10 out of range, 11 parity.
- `init_done` out 1: high once the clear sweep has finished.

## Operation
- **FSM states:** CLEAR and RUN.
  - Reset enters CLEAR with the sweep counter at 0.
  - CLEAR writes 0 to word[counter] each cycle and increments the counter. After word `DEPTH-1` is written, the FSM moves to RUN.
  - RUN is terminal until the next reset.
- **Ready:** `req_ready` = 1 only in RUN. A request is accepted when `req_valid & req_ready`. Requests presented during CLEAR are neither accepted nor queued.
- **Address decode:** word index = `req_addr[clog2(DEPTH)+1:2]`.
  - Misaligned: `req_addr[1:0] != 0`. Takes priority over out of range.
  - Out of range: `req_addr >> 2 >= DEPTH`, i.e. any upper address bit set.
  - On any error: no array write, response `rdata` = 0.
- **Write:** only lanes with `req_be[i]=1` are updated; others are unchanged. `be`=0 is legal: no change, ok response.
- **Read:** returns the word as stored at the accept edge.
  - A read accepted the cycle after a write to the same word returns the new data.
  - Back-to-back requests are supported; throughput is 1 per cycle.
- **Reset:** `reset_n` low at any edge restarts CLEAR. Any response due on the following edge is discarded.

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=00, `init_done`=0, FSM=CLEAR, counter=0.
- Clear sweep takes `DEPTH` cycles after reset release. `req_ready` and `init_done` rise together on the edge ending the sweep.
- Latency: request accepted at edge N produces `rsp_valid`=1 with `rdata`/`err` after edge N+1, held for exactly one cycle. Every accepted request, read or write, gets exactly one response.
- No response backpressure; the consumer must take the response in the cycle it is valid.

## Configuration
- `DMEM_PARITY_EN` defined:
  - One even-parity bit is stored per byte lane and written with its lane.
  - The CLEAR sweep writes parity 0.
  - A read of a valid address recomputes parity. Any lane mismatch gives `rsp_err`=11 with `rdata` still returned.
  - Misaligned and out-of-range errors take priority over parity.
- `DMEM_PARITY_EN` undefined: no parity storage, and code 11 is never produced.

## Structure
- `dmem_pkg` holds:
  - error-code constants `DMEM_OK`, `DMEM_MISALIGN`, `DMEM_RANGE`, `DMEM_PARITY`;
  - the FSM state typedef (CLEAR, RUN).
- Sub-module `dmem_array`:
  - `DEPTH` x `DATA_W` storage with per-lane write enable and a synchronous read port;
  - optional parity lanes under the macro.
- Top level holds the FSM, clear counter, address checks and response registers.

## Test plan
- Reset, then hold `reset_n` high → `req_ready`=0 for 1024 cycles, then `req_ready`=`init_done`=1. A read of addr 0 returns 0, err 00.
- Write addr 48, data 392544, be 4'hF; then read addr 48 the next cycle → `rsp_rdata`=392544, err 00, response 1 cycle after each accept.
- Write addr 50, data 456 → `rsp_err`=01, no array change. A read of addr 48 still returns 392544.
- Write addr 100000, data 154869 (`DEPTH`=1024) → err 10. A read of addr 100000 → err 10, `rdata` 0.
- Write addr 24, data 32'h11223344, be 4'hF; then addr 24, data 32'hAABBCCDD, be 4'b0101; then read addr 24 → 32'h11BB33DD.
- Assert `reset_n` low for one cycle in the same cycle a read is accepted → no `rsp_valid`, `req_ready`=0, CLEAR restarts. After 1024 cycles, a read of addr 48 returns 0.
